// File: rtl/vmem_pkg.sv
// Shared types and constants for the vector-memory load/store sequencer.
package vmem_pkg;

  localparam int unsigned VMEM_DATA_W      = 256;
  localparam int unsigned VMEM_ADDR_W      = 10;
  localparam int unsigned VMEM_ADDR_STRIDE = 4;

  typedef enum logic [2:0] {
    IDLE,
    WR_BEAT,
    WR_RSP,
    RD_WAIT,
    RD_RSP
  } lsu_state_e;

  // Address increment wrapped to an aw-bit word address space.
  function automatic logic [31:0] addr_wrap_inc(input logic [31:0] addr,
                                                input int unsigned stride,
                                                input int unsigned aw);
    logic [31:0] mask;
    mask = (aw >= 32) ? '1 : ((32'd1 << aw) - 32'd1);
    return (addr + stride) & mask;
  endfunction

endpackage

// File: rtl/vmem_lsu_lat_ctr.sv
// Read-latency down-counter; done is high once READ_LAT cycles have elapsed since load.
module vmem_lsu_lat_ctr
  import vmem_pkg::*;
#(
  parameter int unsigned READ_LAT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int unsigned CW = 2;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(READ_LAT);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/vmem_lsu.sv
// Load/store sequencer for the 256-bit vector data memory: one burst request at a time,
// store beats written combinationally, load beats returned one at a time after READ_LAT.
module vmem_lsu
  import vmem_pkg::*;
#(
  parameter int unsigned DATA_W      = VMEM_DATA_W,
  parameter int unsigned ADDR_W      = VMEM_ADDR_W,
  parameter int unsigned ADDR_STRIDE = VMEM_ADDR_STRIDE,
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned MAX_BURST   = 8,
  parameter int unsigned READ_LAT    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rsp_wr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nx;
  logic [LEN_W-1:0]  beats_q;
  logic [LEN_W-1:0]  len_eff;
  logic [DATA_W-1:0] rdata_q;
  logic              lat_load;
  logic              lat_done;
  logic              last_beat;

  assign len_eff   = ((req_len == '0) || (32'(req_len) > MAX_BURST)) ? LEN_W'(1) : req_len;
  assign addr_nx   = ADDR_W'(addr_wrap_inc(32'(addr_q), ADDR_STRIDE, ADDR_W));
  assign last_beat = (beats_q == LEN_W'(1));

  vmem_lsu_lat_ctr #(
    .READ_LAT(READ_LAT)
  ) u_lat_ctr (
    .clk (clk),
    .rst (rst),
    .load(lat_load),
    .en  (state == RD_WAIT),
    .done(lat_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // req_ready is the only output that is nonzero in IDLE, so it alone needs rst gating.
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    wd_ready  = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_last  = 1'b0;
    rsp_wr    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    lat_load  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = ~rst;
        if (req_valid) begin
          state_nx = req_we ? WR_BEAT : RD_WAIT;
          lat_load = ~req_we;
        end
      end
      WR_BEAT: begin
        wd_ready  = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wd_data;
        if (wd_valid) begin
          mem_we = 1'b1;
          if (last_beat) state_nx = WR_RSP;
        end
      end
      WR_RSP: begin
        rsp_valid = 1'b1;
        rsp_wr    = 1'b1;
        rsp_last  = 1'b1;
        mem_addr  = addr_q;
        if (rsp_ready) state_nx = IDLE;
      end
      RD_WAIT: begin
        mem_addr = addr_q;
        if (lat_done) state_nx = RD_RSP;
      end
      RD_RSP: begin
        rsp_valid = 1'b1;
        rsp_last  = last_beat;
        rsp_data  = rdata_q;
        mem_addr  = addr_q;
        if (rsp_ready) begin
          if (last_beat) begin
            state_nx = IDLE;
          end else begin
            state_nx = RD_WAIT;
            lat_load = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      beats_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            beats_q <= len_eff;
          end
        end
        WR_BEAT: begin
          if (wd_valid) begin
            addr_q  <= addr_nx;
            beats_q <= beats_q - 1'b1;
          end
        end
        RD_WAIT: begin
          if (lat_done) rdata_q <= mem_rdata;
        end
        RD_RSP: begin
          if (rsp_ready && !last_beat) begin
            addr_q  <= addr_nx;
            beats_q <= beats_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/vmem_lsu.md
Name: vmem_lsu

Overview:
- Initiator-side load/store sequencer for the 256-bit vector data memory.
- Accepts one load or store request from the PE pipeline, covering 1..MAX_BURST consecutive words.
- Drives the memory's write-enable, address and write-data pins and captures read data after a fixed read latency.
- Returns read beats or a single write completion to the pipeline over valid/ready handshakes.

Parameters:
- DATA_W, 256, word width in bits.
- ADDR_W, 10, memory word-address width (1024 words).
- ADDR_STRIDE, 4, address increment between consecutive beats.
- LEN_W, 4, width of the burst-length field.
- MAX_BURST, 8, largest legal burst length.
- READ_LAT, 0, cycles from mem_addr stable to mem_rdata valid; legal range 0..3.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1=store, 0=load.
- req_addr  in  ADDR_W  start word address.
- req_len  in  LEN_W  number of beats, 1..MAX_BURST.
- wd_valid  in  1  store data beat present.
- wd_ready  out  1  store beat accepted this cycle.
- wd_data  in  DATA_W  store data beat.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  pipeline accepts the response.
- rsp_data  out  DATA_W  load data; 0 on store completion.
- rsp_last  out  1  final response of the request.
- rsp_wr  out  1  response is a store completion.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset: on rst high, outputs go 0 immediately, regardless of clk. This covers req_ready, wd_ready, rsp_*, mem_we, mem_addr and mem_wdata. The FSM enters IDLE and beat/latency counters clear.
- Reset mid-burst: the request is abandoned and no further mem_we pulses occur. Writes already committed remain in memory.
- FSM states: IDLE, WR_BEAT, WR_RSP, RD_WAIT, RD_RSP.
- IDLE:
  - req_ready=1.
  - Accept occurs when req_valid and req_ready are both high. The block then latches we, addr and len, and sets beat count := len.
  - Next state is WR_BEAT for a store and RD_WAIT for a load.
  - req_len=0 or req_len>MAX_BURST: the block treats the value as 1.
- WR_BEAT:
  - wd_ready=1 and mem_addr=current address.
  - On wd_valid: mem_we=1 combinationally, with mem_wdata=wd_data, in the same cycle. The address then advances by ADDR_STRIDE and beat count decrements.
  - After the last beat, next state is WR_RSP.
- WR_RSP:
  - rsp_valid=1, rsp_wr=1, rsp_last=1, rsp_data=0.
  - Holds until rsp_ready, then returns to IDLE.
- RD_WAIT:
  - mem_addr=current address, held stable. A latency counter counts READ_LAT cycles.
  - With READ_LAT=0 the block samples mem_rdata in the entry cycle, at the clock edge.
  - The sample is registered into rsp_data, then next state is RD_RSP.
- RD_RSP:
  - rsp_valid=1, rsp_wr=0, rsp_last=(beat count==1). rsp_data is held stable while rsp_ready=0.
  - On rsp_ready: if this is the last beat, go to IDLE. Otherwise advance the address by ADDR_STRIDE, decrement the beat count and return to RD_WAIT.
- Read throughput: one beat per READ_LAT+2 cycles with no backpressure. No overlap of beats.
- Address arithmetic: mod 2^ADDR_W; 1022+4 wraps to 2.
- mem_we is never asserted outside WR_BEAT.
- req_ready is low in every state except IDLE. Requests arriving while busy wait, and their fields may change freely until accepted.
- A new request is accepted no earlier than the cycle after the final rsp handshake.
- mem_addr and mem_wdata are 0 in IDLE.

Decomposition:
- Shared package `vmem_pkg`:
  - state enum (IDLE..RD_RSP);
  - DATA_W, ADDR_W and ADDR_STRIDE constants;
  - function for the wrapped address increment.
- One sub-module, `vmem_lsu_lat_ctr`: a READ_LAT down-counter with a done flag. Everything else stays in one FSM module.

Test Plan:
- Load, len=2, addr=100, READ_LAT=0, memory preloaded:
  - mem[100]=256'h…09_…0A…10 and mem[104]=256'h…01…08.
  - Required: two rsp_valid beats carrying those values, with rsp_last=0 then 1. mem_we stays 0 throughout.
- Store, len=3, addr=200, wd_data 0xA,0xB,0xC with a 1-cycle wd_valid gap:
  - exactly three mem_we pulses at addr 200, 204, 208 with matching data;
  - one rsp with rsp_wr=1, rsp_last=1.
- Read backpressure, len=2, rsp_ready held low 5 cycles:
  - rsp_data is stable and rsp_valid stays high;
  - mem_addr does not advance until the handshake.
- Wrap-around: load, addr=1020, len=2 -> second beat reads addr 0 (1024 mod 1024).
- READ_LAT=2 build, load, len=1:
  - rsp_valid rises 3 cycles after the accept edge;
  - rsp_data equals mem_rdata at the RD_WAIT exit edge.
- Async reset mid-store, after beat 1 of 4:
  - mem_we, req_ready and rsp_valid drop without a clock edge;
  - after release, req_ready=1 and no further writes occur; mem[addr+4] is unchanged.
